// File: rtl/relu_pool_writer_pkg.sv
// Shared definitions for the ReLU + 2x2 max-pool feature-map writer.
// - rpw_state_t : frame sequencing states (IDLE, ROW_A, ROW_B, DRAIN, DONE)
// - RELU_W      : width of a lane after ReLU (sign dropped, value already saturated)
// - umax        : unsigned maximum of two post-ReLU lanes
package relu_pool_writer_pkg;

  localparam int RELU_W = 16;

  typedef enum logic [2:0] {
    RPW_IDLE  = 3'd0,
    RPW_ROW_A = 3'd1,
    RPW_ROW_B = 3'd2,
    RPW_DRAIN = 3'd3,
    RPW_DONE  = 3'd4
  } rpw_state_t;

  function automatic logic [RELU_W-1:0] umax(input logic [RELU_W-1:0] a,
                                             input logic [RELU_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_pool_writer_pool_max2.sv
// Lane-wise unsigned maximum of two packed vectors of RELU_W-bit lanes.
// Purely combinational; used both for the horizontal lane-pair max and for
// the vertical max of the stored first row against the second row.
// Ports:
//   a, b : LANES x RELU_W packed operands, lane k at [k*RELU_W +: RELU_W]
//   y    : LANES x RELU_W packed lane-wise maximum
module pool_max2
  import relu_pool_writer_pkg::*;
#(
  parameter int LANES = 56
) (
  input  logic [LANES*RELU_W-1:0] a,
  input  logic [LANES*RELU_W-1:0] b,
  output logic [LANES*RELU_W-1:0] y
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign y[gi*RELU_W +: RELU_W] = umax(a[gi*RELU_W +: RELU_W], b[gi*RELU_W +: RELU_W]);
  end

endmodule

// File: rtl/relu_pool_writer.sv
// ReLU + 2x2 max-pool stage feeding the feature-map BRAM writer.
// Each input beat carries MAC_NUM signed DW-bit conv results. Lanes are
// rectified, adjacent lane pairs are max-reduced, and two consecutive beats
// (rows) are max-reduced into one MAC_NUM/2 x 16-bit pooled row, which is
// written out with an address that increments from base_addr.
// Ports:
//   clk, rst            : clock; synchronous active-low reset
//   start               : frame start pulse, honoured only while idle
//   base_addr, row_pairs: first write address / pooled rows in this frame
//   in_vld/in_rdy/in_data    : input beat handshake and payload
//   out_vld/out_rdy/out_addr/out_data : pooled-row handshake, address, payload
//   busy, done          : frame in progress / one-cycle completion pulse
module relu_pool_writer
  import relu_pool_writer_pkg::*;
#(
  parameter int MAC_NUM = 112,
  parameter int DW      = 17,
  parameter int AW      = 12,
  parameter int CW      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [AW-1:0]                 base_addr,
  input  logic [CW-1:0]                 row_pairs,
  input  logic                          in_vld,
  input  logic [MAC_NUM*DW-1:0]         in_data,
  output logic                          in_rdy,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [AW-1:0]                 out_addr,
  output logic [MAC_NUM/2*RELU_W-1:0]   out_data,
  output logic                          busy,
  output logic                          done
);

  localparam int OL = MAC_NUM / 2;

  rpw_state_t              state_reg, state_next;
  logic [CW-1:0]           rows_reg;
  logic [CW-1:0]           cnt_reg;
  logic [AW-1:0]           addr_reg;
  logic [OL*RELU_W-1:0]    partial_reg;
  logic [OL*RELU_W-1:0]    out_data_reg;
  logic [AW-1:0]           out_addr_reg;
  logic                    out_vld_reg;

  logic [MAC_NUM*RELU_W-1:0] relu_lanes;
  logic [OL*RELU_W-1:0]      even_lanes, odd_lanes, hmax, vmax;
  logic                      accept, load_row;

  // Upstream saturates to the 16-bit unsigned range, so a non-negative lane
  // fits in its low RELU_W bits; negative lanes rectify to zero.
  for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_relu
    assign relu_lanes[gi*RELU_W +: RELU_W] =
      in_data[gi*DW + DW - 1] ? '0 : in_data[gi*DW +: RELU_W];
  end

  for (genvar gi = 0; gi < OL; gi++) begin : g_split
    assign even_lanes[gi*RELU_W +: RELU_W] = relu_lanes[(2*gi)*RELU_W +: RELU_W];
    assign odd_lanes[gi*RELU_W +: RELU_W]  = relu_lanes[(2*gi+1)*RELU_W +: RELU_W];
  end

  pool_max2 #(.LANES(OL)) u_hmax (.a(even_lanes),  .b(odd_lanes), .y(hmax));
  pool_max2 #(.LANES(OL)) u_vmax (.a(partial_reg), .b(hmax),      .y(vmax));

  // Second-row beats may only enter when the output register is free or is
  // being emptied this very cycle.
  assign in_rdy   = (state_reg == RPW_ROW_A) ||
                    ((state_reg == RPW_ROW_B) && (!out_vld_reg || out_rdy));
  assign accept   = in_vld && in_rdy;
  assign load_row = (state_reg == RPW_ROW_B) && accept;

  assign busy     = (state_reg == RPW_ROW_A) || (state_reg == RPW_ROW_B) ||
                    (state_reg == RPW_DRAIN);
  assign done     = (state_reg == RPW_DONE);
  assign out_vld  = out_vld_reg;
  assign out_addr = out_addr_reg;
  assign out_data = out_data_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RPW_IDLE:  if (start) state_next = (row_pairs == '0) ? RPW_DONE : RPW_ROW_A;
      RPW_ROW_A: if (accept) state_next = RPW_ROW_B;
      RPW_ROW_B: if (accept) state_next = (cnt_reg == rows_reg - CW'(1)) ? RPW_DRAIN : RPW_ROW_A;
      RPW_DRAIN: if (!out_vld_reg || out_rdy) state_next = RPW_DONE;
      RPW_DONE:  state_next = RPW_IDLE;
      default:   state_next = RPW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= RPW_IDLE;
      rows_reg     <= '0;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      partial_reg  <= '0;
      out_data_reg <= '0;
      out_addr_reg <= '0;
      out_vld_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == RPW_IDLE) && start) begin
        rows_reg <= row_pairs;
        cnt_reg  <= '0;
        addr_reg <= base_addr;
      end
      if ((state_reg == RPW_ROW_A) && accept) begin
        partial_reg <= hmax;
      end
      // A new row loaded in the same cycle the old one is taken keeps out_vld high.
      if (load_row) begin
        out_data_reg <= vmax;
        out_addr_reg <= addr_reg;
        out_vld_reg  <= 1'b1;
        addr_reg     <= addr_reg + AW'(1);
        cnt_reg      <= cnt_reg + CW'(1);
      end else if (out_vld_reg && out_rdy) begin
        out_vld_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_pool_writer.sv
module tb_relu_pool_writer;

  localparam int MAC = 4;
  localparam int DW  = 17;
  localparam int AW  = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [CW-1:0]     row_pairs = '0;
  logic              in_vld = 1'b0;
  logic [MAC*DW-1:0] in_data = '0;
  logic              in_rdy;
  logic              out_vld;
  logic              out_rdy = 1'b0;
  logic [AW-1:0]     out_addr;
  logic [MAC/2*16-1:0] out_data;
  logic              busy;
  logic              done;

  relu_pool_writer #(.MAC_NUM(MAC), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_pairs(row_pairs),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  typedef struct {
    int a[4];
    int b[4];
    int base;
    int y0;
    int y1;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   done_cnt = 0;
  int   n_out = 0;
  bit   rdy_rand = 0;
  bit   rdy_manual = 1;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [MAC*DW-1:0] pack(input int v[4]);
    logic [MAC*DW-1:0] p;
    p = '0;
    for (int j = 0; j < MAC; j++) p[j*DW +: DW] = 17'(v[j]);
    return p;
  endfunction

  // Reference: each pooled lane is the largest rectified value of its 2x2 quad.
  function automatic logic [31:0] model_pool(input int a[4], input int b[4]);
    logic [31:0] res;
    int q[4];
    int m;
    res = '0;
    for (int k = 0; k < 2; k++) begin
      q[0] = a[2*k]; q[1] = a[2*k+1]; q[2] = b[2*k]; q[3] = b[2*k+1];
      m = 0;
      for (int i = 0; i < 4; i++) if (q[i] > m) m = q[i];
      res[k*16 +: 16] = m[15:0];
    end
    return res;
  endfunction

  function automatic int rand_lane();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_manual;
  end

  always @(negedge clk) if (rst && done) done_cnt++;

  // Scoreboard: every accepted pooled row must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      exp_t e;
      n_out++;
      last_acc_cyc = cyc;
      $display("write addr=%0d data=%08h", out_addr, out_data);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_data", out_data, e.data);
      end
    end
  end

  task automatic start_frame(input int base, input int rows);
    start = 1'b1;
    base_addr = AW'(base);
    row_pairs = CW'(rows);
    @(posedge clk); #1;
    start = 1'b0;
    if (rows != 0) chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic send_beat(input int v[4]);
    bit ok;
    ok = 0;
    in_vld = 1'b1;
    in_data = pack(v);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    if (!ok) chk("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    bit ok;
    int dcyc;
    ok = 0;
    dcyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; dcyc = cyc; break; end
    end
    chk("done_seen", ok, 1'b1);
    if (ok) begin
      chk("done_latency", dcyc, last_acc_cyc + 1);
      chk("busy_at_done", busy, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
    end
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic random_frame(input int base, input int rows);
    int a[4];
    int b[4];
    exp_t e;
    start_frame(base, rows);
    for (int r = 0; r < rows; r++) begin
      for (int j = 0; j < 4; j++) begin a[j] = rand_lane(); b[j] = rand_lane(); end
      e.addr = AW'(base + r);
      e.data = model_pool(a, b);
      exp_q.push_back(e);
      send_beat(a);
      send_beat(b);
    end
    wait_done();
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1[4], b1[4], a2[4], b2[4];
    int d0, n0;
    exp_t e, e1;

    vecs[0].a = '{5, 9, -2, 1};          vecs[0].b = '{7, 2, -8, -3};
    vecs[0].base = 3;  vecs[0].y0 = 9;   vecs[0].y1 = 1;
    vecs[1].a = '{-100, -100, -100, -100}; vecs[1].b = '{-100, -100, -100, -100};
    vecs[1].base = 7;  vecs[1].y0 = 0;   vecs[1].y1 = 0;
    vecs[2].a = '{65535, 0, 3, 3};       vecs[2].b = '{0, 1, -1, 2};
    vecs[2].base = 0;  vecs[2].y0 = 65535; vecs[2].y1 = 3;
    vecs[3].a = '{4, 4, 4, 4};           vecs[3].b = '{4, 4, 4, 4};
    vecs[3].base = 12; vecs[3].y0 = 4;   vecs[3].y1 = 4;
    vecs[4].a = '{-1, -65536, 0, 0};     vecs[4].b = '{-5, -5, 300, -5};
    vecs[4].base = 15; vecs[4].y0 = 0;   vecs[4].y1 = 300;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_addr", out_addr, '0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven single-row-pair frames with hand-computed results
    rdy_manual = 1;
    for (int t = 0; t < 5; t++) begin
      e.addr = AW'(vecs[t].base);
      e.data = {vecs[t].y1[15:0], vecs[t].y0[15:0]};
      exp_q.push_back(e);
      n0 = n_out;
      d0 = done_cnt;
      start_frame(vecs[t].base, 1);
      send_beat(vecs[t].a);
      chk("in_rdy_idle_after_a", in_rdy, 1'b1);
      send_beat(vecs[t].b);
      chk("out_vld_next_cycle", out_vld, 1'b1);
      wait_done();
      chk("table_write_count", n_out - n0, 1);
      chk("table_done_count", done_cnt - d0, 1);
    end

    // Backpressure: first row held while second ROW_B must stall
    rdy_manual = 0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      a1[j] = rand_lane(); b1[j] = rand_lane(); a2[j] = rand_lane(); b2[j] = rand_lane();
    end
    e1.addr = 4'd3; e1.data = model_pool(a1, b1);
    e.addr  = 4'd4; e.data  = model_pool(a2, b2);
    exp_q.push_back(e1);
    exp_q.push_back(e);
    n0 = n_out;
    start_frame(3, 2);
    send_beat(a1);
    send_beat(b1);
    chk("bp_out_vld", out_vld, 1'b1);
    send_beat(a2);
    in_vld = 1'b1;
    in_data = pack(b2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_rdy_low", in_rdy, 1'b0);
      chk("bp_out_vld_held", out_vld, 1'b1);
      chk("bp_data_stable", out_data, e1.data);
      chk("bp_addr_stable", out_addr, 4'd3);
    end
    @(posedge clk); #1;
    rdy_manual = 1;
    send_beat(b2);
    wait_done();
    chk("bp_write_count", n_out - n0, 2);

    // Zero-row frame: done the cycle after start, nothing written
    d0 = done_cnt;
    start_frame(5, 0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_out_vld", out_vld, 1'b0);
    @(posedge clk); #1;
    chk("zero_done_pulse", done, 1'b0);
    chk("zero_done_count", done_cnt - d0, 1);

    // Address wrap
    n0 = n_out;
    random_frame(15, 2);
    chk("wrap_write_count", n_out - n0, 2);

    // Reset mid-frame while a row is waiting in ROW_B
    rdy_manual = 0;
    @(posedge clk); #1;
    d0 = done_cnt;
    start_frame(7, 2);
    send_beat(a1);
    send_beat(b1);
    send_beat(a2);
    chk("mid_out_vld_before", out_vld, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_out_vld", out_vld, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_in_rdy", in_rdy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt - d0, 0);
    exp_q.delete();
    rdy_manual = 1;
    n0 = n_out;
    random_frame(9, 1);
    chk("post_reset_writes", n_out - n0, 1);

    // Start while busy is ignored
    d0 = done_cnt;
    n0 = n_out;
    e.addr = 4'd2; e.data = model_pool(a1, b1); exp_q.push_back(e);
    e.addr = 4'd3; e.data = model_pool(a2, b2); exp_q.push_back(e);
    start_frame(2, 2);
    send_beat(a1);
    start = 1'b1; base_addr = 4'd9; row_pairs = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(b1);
    send_beat(a2);
    send_beat(b2);
    wait_done();
    repeat (6) @(posedge clk);
    #1;
    chk("busy_start_done_count", done_cnt - d0, 1);
    chk("busy_start_writes", n_out - n0, 2);
    chk("busy_start_idle", busy, 1'b0);

    // Randomized frames with random sink backpressure
    rdy_rand = 1;
    for (int f = 0; f < 8; f++) begin
      random_frame(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
    end
    rdy_rand = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
